// File: rtl/byte_serial_subtractor32.sv
// Multi-cycle a - b, one byte per clock via a + ~b + 1 with the carry held in a register.
// A start/busy/done handshake lets a control FSM launch one subtraction at a time.
module byte_serial_subtractor32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICE = WIDTH / 8;
    localparam int IW     = $clog2(NSLICE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic [8:0]       w_sum9;
    logic [WIDTH-1:0] w_diff_new;
    logic             w_accept;
    logic             w_last;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_idx == IW'(NSLICE - 1));

    always_comb begin
        w_a_byte = 8'd0;
        w_b_byte = 8'd0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_byte = r_a[8*i +: 8];
                w_b_byte = r_b[8*i +: 8];
            end
        end
    end

    assign w_sum9 = {1'b0, w_a_byte} + {1'b0, ~w_b_byte} + {8'd0, r_carry};

    // Diff as it will look after this edge; flags are derived from it so they land with the top byte.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign w_diff_new[8*gi +: 8] = (r_idx == IW'(gi)) ? w_sum9[7:0] : r_diff[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b1;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b1;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_diff  <= w_diff_new;
            r_carry <= w_sum9[8];
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                r_borrow <= ~w_sum9[8];
                r_ovf    <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_new[WIDTH-1] != r_a[WIDTH-1]);
                r_zero   <= (w_diff_new == '0);
            end
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign ovf        = r_ovf;
    assign zero       = r_zero;

endmodule

// File: doc/byte_serial_subtractor32.md
Name: byte_serial_subtractor32

Overview:
Multi-cycle WIDTH-bit subtractor computing a - b one byte per cycle. It chains an 8-bit add slice as a + ~b + 1 and carries the inter-byte carry/borrow in a register. It is used in the multicycle datapath for SUB/SUBU/SLT/BEQ-style comparisons where area matters more than latency. A start/busy/done handshake interfaces it to the control FSM.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 8; NSLICE = WIDTH/8 cycles of compute.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  minuend; sampled at the start-accept edge only
b  input  WIDTH  subtrahend; sampled at the start-accept edge only
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse; results valid from this cycle
diff  output  WIDTH  a - b, modulo 2^WIDTH
borrow_out  output  1  1 when unsigned a < b (inverted final carry)
ovf  output  1  signed two's-complement overflow of a - b
zero  output  1  diff == 0

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, borrow_out=0, ovf=0, zero=0; internal byte index=0, carry=1, operand registers=0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start=1 is accepted at a rising edge when state is IDLE or DONE.
  - At that edge: latch a and b, set index=0, set carry=1, clear diff, go to RUN.
  - busy=1 throughout RUN.
- RUN, edge k (k=0..NSLICE-1):
  - sum9 = A[8k+7:8k] + ~B[8k+7:8k] + carry.
  - diff[8k+7:8k] <= sum9[7:0]; carry <= sum9[8]; index <= k+1.
  - At the edge with k=NSLICE-1, go to DONE.
- Flag generation on entry to DONE, registered on the same edge as the top byte:
  - borrow_out = ~final carry.
  - ovf = (A[W-1] != B[W-1]) & (diff[W-1] != A[W-1]), using the new top byte.
  - zero = (full new diff == 0).
- DONE lasts one cycle: done=1, busy=0. Next state is RUN if start=1, otherwise IDLE.
- Latency: the start-accept edge is E0; done is high in the cycle after edge E(NSLICE), i.e. 5 cycles after the start-accept edge for WIDTH=32. Back-to-back throughput is one result per NSLICE+1 cycles.
- Output hold: diff, borrow_out, ovf and zero hold their values from DONE until the next start is accepted. At the accept edge diff and the flags clear to 0.
- Ignored inputs:
  - start while busy=1 is ignored. It is not queued.
  - a and b changes after the accept edge have no effect.
- Reset mid-RUN aborts immediately to the reset values. No done pulse is produced for the aborted operation.
- Boundary cases:
  - a == b gives diff=0, zero=1, borrow_out=0, ovf=0.
  - Borrow propagates across every byte boundary through the carry register.
  - Same-sign operands never set ovf.

Test Plan:
- Reset, then start with a=5, b=3 -> busy high for 4 cycles; done pulses in the 5th cycle after accept; diff=0x00000002, borrow_out=0, ovf=0, zero=0.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow_out=1, ovf=0, zero=0. Also a=0x00000100, b=0x00000001 -> diff=0x000000FF, exercising inter-byte borrow.
- Signed overflow cases:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, borrow_out=0.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow_out=1.
- a=b=0xDEADBEEF -> diff=0, zero=1, borrow_out=0, ovf=0.
- Start 10-4, then pulse start with a=99, b=1 during RUN -> second request ignored; result 6. Start asserted during the DONE cycle with a=9, b=2 -> accepted; done again 5 cycles later with diff=7.
- Assert rst for 1 cycle during RUN, at the byte-2 edge -> all outputs 0 immediately, no done pulse. A fresh start of 3-5 then gives diff=0xFFFFFFFE, borrow_out=1.
